sm83_alu_seq: RTL and testbench
===============================

Name: sm83_alu_seq

Overview:
Micro-sequencer that drives the control side of the nibble-serial sm83_alu for the eight 8-bit accumulator ops (ADD, ADC, SUB, SBC, AND, XOR, OR, CP). It accepts an operation request through a valid/ready handshake and loads both operands into the ALU. It runs the low and high nibble passes, reads back the result, and returns the result plus the Z/N/H/C flags through a second valid/ready handshake. It sits between the CPU decode/control logic and the ALU instance.

Parameters:
ALU_WIDTH, 4, nibble width of the attached ALU; word width W = 2*ALU_WIDTH.

Ports:
clk  in  1  clock; all state updates on posedge.
reset  in  1  asynchronous, active-high reset.
req_valid  in  1  request valid.
req_ready  out  1  request accepted when req_valid && req_ready.
req_op  in  3  0 ADD, 1 ADC, 2 SUB, 3 SBC, 4 AND, 5 XOR, 6 OR, 7 CP.
req_a  in  W  operand A (accumulator).
req_b  in  W  operand B.
req_carry  in  1  incoming C flag (used by ADC/SBC).
rsp_valid  out  1  response valid.
rsp_ready  in  1  response consumed when rsp_valid && rsp_ready.
rsp_result  out  W  result; for CP this equals the captured A.
rsp_flags  out  4  {Z, N, H, C}.
alu_din  out  W  to ALU din.
alu_load_a, alu_load_b  out  1 each  ALU operand loads.
alu_shift_oe, alu_result_oe  out  1 each  ALU bus selects.
alu_op_low, alu_op_b_high  out  1 each  nibble selects.
alu_carry_in, alu_negate  out  1 each  ALU core controls.
alu_no_carry_out, alu_force_carry, alu_ignore_carry  out  1 each  R/S/V.
alu_dout  in  W  ALU bus readback.
alu_carry  in  1  ALU nibble carry out.
alu_zero  in  1  ALU bus-zero.

Behaviour:
- Reset (async, immediate): state IDLE; every output 0, including rsp_result, rsp_flags and all alu_* controls.
- States:
  - IDLE: req_ready=1. On accept, capture op/a/b/carry and go to LDA.
  - LDA: alu_din=a, shift_oe=1, load_a=1. Go to LDB.
  - LDB: alu_din=b, shift_oe=1, load_b=1. Go to LOW.
  - LOW: op_low=1, op_b_high=0. At the posedge, latch h_raw=alu_carry. Go to HIGH.
  - HIGH: op_low=0, op_b_high=1. carry_in = h_raw for arithmetic ops, else the per-op constant. At the posedge, latch c_raw=alu_carry. Go to READ.
  - READ: HIGH controls held; result_oe=1. At the posedge, capture rsp_result (alu_dout, or a for CP), Z=alu_zero, N, H, C. Go to RESP.
  - RESP: rsp_valid=1. On rsp_ready go to IDLE; otherwise hold with all outputs stable.
- Control outputs are 0 in every state where they are not named above.
- Per-op controls {R,S,V,negate, carry_in in LOW}:
  - ADD {0,0,0,0,0}; ADC {0,0,0,0,req_carry}.
  - SUB and CP {0,0,0,1,1}; SBC {0,0,0,1,!req_carry}.
  - AND {0,1,0,0,1}; XOR {1,0,0,0,0}; OR {1,1,1,0,0}.
- Flags:
  - N=1 for SUB/SBC/CP, else 0.
  - ADD/ADC: H=h_raw, C=c_raw.
  - SUB/SBC/CP: H=!h_raw, C=!c_raw.
  - AND: H=1, C=0. XOR/OR: H=0, C=0.
- Latency: the accept edge is T; rsp_valid is high from T+6.
- Requests are ignored while req_ready=0. A new request in the same cycle as the RESP handshake is not accepted.
- rsp_result and rsp_flags hold their values until the next READ capture.
- Reset mid-operation aborts the operation with no response. The ALU's internal operand registers are left as-is.

Optional Feature:
SM83_ALU_SEQ_PIPE_EN
- Defined: in RESP, req_ready = rsp_ready. A request accepted in the same cycle as the response handshake goes directly to LDA with no IDLE bubble, giving one op per 6 cycles under continuous traffic.
- Undefined: req_ready is high only in IDLE, giving one op per 7 cycles.

Test Plan:
- ADD a=0x3A b=0xC6 -> rsp_result 0x00, flags Z1 N0 H1 C1; rsp_valid exactly 6 cycles after accept.
- SUB a=0x10 b=0x01 -> 0x0F, Z0 N1 H1 C0. SBC a=0x00 b=0x00 carry=1 -> 0xFF, Z0 N1 H1 C1.
- Logic ops:
  - AND 0xF0,0x0F -> 0x00, Z1 N0 H1 C0.
  - XOR 0x5A,0xFF -> 0xA5, Z0 H0 C0.
  - OR 0x00,0x00 -> 0x00, Z1 H0 C0.
- CP a=0x42 b=0x42 -> rsp_result 0x42, Z1 N1 H0 C0. ADC 0x0F+0x00 carry=1 -> 0x10, H1 C0.
- Hold rsp_ready=0 for 10 cycles -> rsp_valid, rsp_result and rsp_flags stable, req_ready=0, extra req_valid ignored. With SM83_ALU_SEQ_PIPE_EN, back-to-back ops are 6 cycles apart.
- Assert reset while in HIGH -> all outputs 0 in the same cycle, no rsp_valid. The next ADD 0x01+0x01 -> 0x02, flags all 0.

Source files
------------

// File: rtl/sm83_alu_seq.sv
// sm83_alu_seq: micro-sequencer driving the control side of the nibble-serial
// sm83 ALU for the eight 8-bit accumulator ops (ADD ADC SUB SBC AND XOR OR CP).
// Sequence per op: IDLE -> LDA -> LDB -> LOW -> HIGH -> READ -> RESP.
// Optional feature macro: SM83_ALU_SEQ_PIPE_EN. When it is defined, a request
// can be accepted in the RESP handshake cycle, giving one op per 6 cycles
// instead of 7.
//
// Handshake semantics (both req and rsp): a transfer happens on the rising
// clk edge where valid && ready are both high; the sender holds valid and
// payload stable until that edge, and ready never depends on valid.
module sm83_alu_seq #(
  parameter int ALU_WIDTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [2:0]             req_op,
  input  logic [2*ALU_WIDTH-1:0] req_a,
  input  logic [2*ALU_WIDTH-1:0] req_b,
  input  logic                   req_carry,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [2*ALU_WIDTH-1:0] rsp_result,
  output logic [3:0]             rsp_flags,
  output logic [2*ALU_WIDTH-1:0] alu_din,
  output logic                   alu_load_a,
  output logic                   alu_load_b,
  output logic                   alu_shift_oe,
  output logic                   alu_result_oe,
  output logic                   alu_op_low,
  output logic                   alu_op_b_high,
  output logic                   alu_carry_in,
  output logic                   alu_negate,
  output logic                   alu_no_carry_out,
  output logic                   alu_force_carry,
  output logic                   alu_ignore_carry,
  input  logic [2*ALU_WIDTH-1:0] alu_dout,
  input  logic                   alu_carry,
  input  logic                   alu_zero,
  output logic [2:0]             dbg_state
);

  localparam int W = 2 * ALU_WIDTH;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_ADC = 3'd1;
  localparam logic [2:0] OP_SUB = 3'd2;
  localparam logic [2:0] OP_SBC = 3'd3;
  localparam logic [2:0] OP_AND = 3'd4;
  localparam logic [2:0] OP_XOR = 3'd5;
  localparam logic [2:0] OP_OR  = 3'd6;
  localparam logic [2:0] OP_CP  = 3'd7;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LDA  = 3'd1,
    S_LDB  = 3'd2,
    S_LOW  = 3'd3,
    S_HIGH = 3'd4,
    S_READ = 3'd5,
    S_RESP = 3'd6
  } state_t;

  // All ALU control strobes, registered together so they change cleanly.
  typedef struct packed {
    logic load_a;
    logic load_b;
    logic shift_oe;
    logic result_oe;
    logic op_low;
    logic op_b_high;
    logic carry_in;
    logic negate;
    logic no_carry_out;
    logic force_carry;
    logic ignore_carry;
  } ctrl_t;

  state_t       state;
  state_t       nxt_state;
  ctrl_t        ctrl;
  logic [2:0]   op_q;
  logic [W-1:0] a_q;
  logic [W-1:0] b_q;
  logic         carry_q;
  logic         h_raw;
  logic         c_raw;
  logic [W-1:0] din_q;
  logic         req_ready_q;
  logic         rsp_valid_q;
  logic [W-1:0] rsp_result_q;
  logic [3:0]   rsp_flags_q;
  logic         accept;
  logic [3:0]   flags_n;

  // Control word the ALU needs while the FSM sits in state st. hc is the
  // low-nibble carry to feed into the high pass of arithmetic ops.
  function automatic ctrl_t ctrl_for(input state_t st, input logic [2:0] op,
                                     input logic carry, input logic hc);
    ctrl_t c;
    logic  arith;
    logic  sub;
    c     = '0;
    arith = (op == OP_ADD) || (op == OP_ADC) || (op == OP_SUB) ||
            (op == OP_SBC) || (op == OP_CP);
    sub   = (op == OP_SUB) || (op == OP_SBC) || (op == OP_CP);
    case (st)
      S_LDA: begin
        c.shift_oe = 1'b1;
        c.load_a   = 1'b1;
      end
      S_LDB: begin
        c.shift_oe = 1'b1;
        c.load_b   = 1'b1;
      end
      S_LOW, S_HIGH, S_READ: begin
        c.op_low       = (st == S_LOW);
        c.op_b_high    = (st != S_LOW);
        c.result_oe    = (st == S_READ);
        c.negate       = sub;
        c.no_carry_out = (op == OP_XOR) || (op == OP_OR);
        c.force_carry  = (op == OP_AND) || (op == OP_OR);
        c.ignore_carry = (op == OP_OR);
        case (op)
          OP_ADC:  c.carry_in = carry;
          OP_SUB:  c.carry_in = 1'b1;
          OP_CP:   c.carry_in = 1'b1;
          OP_SBC:  c.carry_in = !carry;
          OP_AND:  c.carry_in = 1'b1;
          default: c.carry_in = 1'b0;
        endcase
        if (st != S_LOW && arith) c.carry_in = hc;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

`ifdef SM83_ALU_SEQ_PIPE_EN
  assign req_ready = req_ready_q || ((state == S_RESP) && rsp_ready);
`else
  assign req_ready = req_ready_q;
`endif

  assign accept = req_valid && req_ready;

  // Next-state decode for the op sequence.
  always_comb begin
    nxt_state = state;
    case (state)
      S_IDLE:  nxt_state = accept ? S_LDA : S_IDLE;
      S_LDA:   nxt_state = S_LDB;
      S_LDB:   nxt_state = S_LOW;
      S_LOW:   nxt_state = S_HIGH;
      S_HIGH:  nxt_state = S_READ;
      S_READ:  nxt_state = S_RESP;
      S_RESP:  nxt_state = rsp_ready ? (accept ? S_LDA : S_IDLE) : S_RESP;
      default: nxt_state = S_IDLE;
    endcase
  end

  // Flag decode from the latched nibble carries, evaluated in READ.
  always_comb begin
    flags_n    = '0;
    flags_n[3] = alu_zero;
    case (op_q)
      OP_ADD, OP_ADC: flags_n[1:0] = {h_raw, c_raw};
      OP_SUB, OP_SBC, OP_CP: begin
        flags_n[2]   = 1'b1;
        flags_n[1:0] = {!h_raw, !c_raw};
      end
      OP_AND:  flags_n[1] = 1'b1;
      default: flags_n[1:0] = 2'b00;
    endcase
  end

  // Sequencer state, operand capture and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= S_IDLE;
      ctrl         <= '0;
      op_q         <= '0;
      a_q          <= '0;
      b_q          <= '0;
      carry_q      <= 1'b0;
      h_raw        <= 1'b0;
      c_raw        <= 1'b0;
      din_q        <= '0;
      req_ready_q  <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_result_q <= '0;
      rsp_flags_q  <= '0;
    end else begin
      state <= nxt_state;
      if (accept) begin
        op_q    <= req_op;
        a_q     <= req_a;
        b_q     <= req_b;
        carry_q <= req_carry;
      end
      ctrl <= ctrl_for(nxt_state, accept ? req_op : op_q,
                       accept ? req_carry : carry_q,
                       (state == S_LOW) ? alu_carry : h_raw);
      if (nxt_state == S_LDA)      din_q <= req_a;
      else if (nxt_state == S_LDB) din_q <= b_q;
      else                         din_q <= '0;
      if (state == S_LOW)  h_raw <= alu_carry;
      if (state == S_HIGH) c_raw <= alu_carry;
      if (state == S_READ) begin
        rsp_result_q <= (op_q == OP_CP) ? a_q : alu_dout;
        rsp_flags_q  <= flags_n;
      end
      req_ready_q <= (nxt_state == S_IDLE);
      rsp_valid_q <= (nxt_state == S_RESP);
    end
  end

  assign rsp_valid        = rsp_valid_q;
  assign rsp_result       = rsp_result_q;
  assign rsp_flags        = rsp_flags_q;
  assign alu_din          = din_q;
  assign alu_load_a       = ctrl.load_a;
  assign alu_load_b       = ctrl.load_b;
  assign alu_shift_oe     = ctrl.shift_oe;
  assign alu_result_oe    = ctrl.result_oe;
  assign alu_op_low       = ctrl.op_low;
  assign alu_op_b_high    = ctrl.op_b_high;
  assign alu_carry_in     = ctrl.carry_in;
  assign alu_negate       = ctrl.negate;
  assign alu_no_carry_out = ctrl.no_carry_out;
  assign alu_force_carry  = ctrl.force_carry;
  assign alu_ignore_carry = ctrl.ignore_carry;
  assign dbg_state        = state;

endmodule

// File: tb/tb_sm83_alu_seq.sv
// Testbench for sm83_alu_seq with a behavioural nibble-serial ALU attached.
module tb_sm83_alu_seq;
  localparam int W = 8;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_ADC = 3'd1;
  localparam logic [2:0] OP_SUB = 3'd2;
  localparam logic [2:0] OP_SBC = 3'd3;
  localparam logic [2:0] OP_AND = 3'd4;
  localparam logic [2:0] OP_XOR = 3'd5;
  localparam logic [2:0] OP_OR  = 3'd6;
  localparam logic [2:0] OP_CP  = 3'd7;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic         req_valid = 1'b0;
  logic         req_ready;
  logic [2:0]   req_op = '0;
  logic [W-1:0] req_a = '0;
  logic [W-1:0] req_b = '0;
  logic         req_carry = 1'b0;
  logic         rsp_valid;
  logic         rsp_ready = 1'b0;
  logic [W-1:0] rsp_result;
  logic [3:0]   rsp_flags;
  logic [W-1:0] alu_din;
  logic         alu_load_a, alu_load_b, alu_shift_oe, alu_result_oe;
  logic         alu_op_low, alu_op_b_high, alu_carry_in, alu_negate;
  logic         alu_no_carry_out, alu_force_carry, alu_ignore_carry;
  logic [W-1:0] alu_dout;
  logic         alu_carry;
  logic         alu_zero;
  logic [2:0]   dbg_state;

  sm83_alu_seq #(.ALU_WIDTH(4)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .req_carry(req_carry),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_flags(rsp_flags),
    .alu_din(alu_din), .alu_load_a(alu_load_a), .alu_load_b(alu_load_b),
    .alu_shift_oe(alu_shift_oe), .alu_result_oe(alu_result_oe),
    .alu_op_low(alu_op_low), .alu_op_b_high(alu_op_b_high),
    .alu_carry_in(alu_carry_in), .alu_negate(alu_negate),
    .alu_no_carry_out(alu_no_carry_out), .alu_force_carry(alu_force_carry),
    .alu_ignore_carry(alu_ignore_carry),
    .alu_dout(alu_dout), .alu_carry(alu_carry), .alu_zero(alu_zero),
    .dbg_state(dbg_state)
  );

  // ---------------- behavioural ALU ----------------
  logic [W-1:0] m_a = '0;
  logic [W-1:0] m_b = '0;
  logic [3:0]   m_lo = '0;
  logic [3:0]   m_hi = '0;
  logic [3:0]   nib_a, nib_b, nib_bb, nib_r;
  logic [4:0]   sum5;
  logic         nib_co;

  always_comb begin
    nib_a  = alu_op_b_high ? m_a[7:4] : m_a[3:0];
    nib_b  = alu_op_b_high ? m_b[7:4] : m_b[3:0];
    nib_bb = alu_negate ? ~nib_b : nib_b;
    sum5   = {1'b0, nib_a} + {1'b0, nib_bb} + {4'b0, alu_carry_in};
    nib_r  = 4'hA;
    nib_co = 1'b0;
    case ({alu_no_carry_out, alu_force_carry, alu_ignore_carry})
      3'b000: begin nib_r = sum5[3:0]; nib_co = sum5[4]; end
      3'b010: nib_r = alu_carry_in ? (nib_a & nib_b) : ~(nib_a & nib_b);
      3'b100: nib_r = alu_carry_in ? ~(nib_a ^ nib_b) : (nib_a ^ nib_b);
      3'b111: nib_r = alu_carry_in ? 4'h0 : (nib_a | nib_b);
      default: nib_r = 4'hA;
    endcase
  end

  always @(posedge clk) begin
    if (alu_shift_oe && alu_load_a) m_a <= alu_din;
    if (alu_shift_oe && alu_load_b) m_b <= alu_din;
    if (alu_op_low)    m_lo <= nib_r;
    if (alu_op_b_high) m_hi <= nib_r;
  end

  assign alu_carry = nib_co;
  assign alu_dout  = alu_result_oe ? {m_hi, m_lo} : (alu_shift_oe ? alu_din : '0);
  assign alu_zero  = (alu_dout == '0);

  // ---------------- scoreboard ----------------
  int checks = 0;
  int failures = 0;
  logic [11:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] all_outputs();
    return {31'b0, req_ready, rsp_valid, rsp_result, rsp_flags, alu_din,
            alu_load_a, alu_load_b, alu_shift_oe, alu_result_oe, alu_op_low,
            alu_op_b_high, alu_carry_in, alu_negate, alu_no_carry_out,
            alu_force_carry, alu_ignore_carry};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic send_req(input logic [2:0] op, input logic [7:0] a,
                          input logic [7:0] b, input logic c);
    int n;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("req_ready_wait", {63'b0, req_ready}, 64'd1);
    req_valid = 1'b1;
    req_op    = op;
    req_a     = a;
    req_b     = b;
    req_carry = c;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  // Called #1 after an accept edge; returns cycles until rsp_valid seen.
  task automatic wait_rsp(output int lat);
    lat = 1;
    while (!rsp_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("rsp_valid_wait", {63'b0, rsp_valid}, 64'd1);
  endtask

  task automatic compare_rsp(input string tag);
    logic [11:0] e;
    if (exp_q.size() == 0) begin
      check({tag, "_queue"}, 64'd0, 64'd1);
    end else begin
      e = exp_q.pop_front();
      check({tag, "_result"}, {56'b0, rsp_result}, {56'b0, e[11:4]});
      check({tag, "_flags"}, {60'b0, rsp_flags}, {60'b0, e[3:0]});
    end
  endtask

  task automatic release_rsp(input string tag);
    @(negedge clk);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    check({tag, "_rsp_drop"}, {63'b0, rsp_valid}, 64'd0);
  endtask

  // ---------------- vectors ----------------
  typedef struct {
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic       c;
    logic [7:0] res;
    logic [3:0] flags; // {Z,N,H,C}
  } vec_t;

  localparam int NV = 14;
  vec_t vecs[NV];

  initial begin
    int lat;
    int seen;
    int n;

    vecs[0]  = '{OP_ADD, 8'h3A, 8'hC6, 1'b0, 8'h00, 4'b1011};
    vecs[1]  = '{OP_SUB, 8'h10, 8'h01, 1'b0, 8'h0F, 4'b0110};
    vecs[2]  = '{OP_SBC, 8'h00, 8'h00, 1'b1, 8'hFF, 4'b0111};
    vecs[3]  = '{OP_AND, 8'hF0, 8'h0F, 1'b0, 8'h00, 4'b1010};
    vecs[4]  = '{OP_XOR, 8'h5A, 8'hFF, 1'b0, 8'hA5, 4'b0000};
    vecs[5]  = '{OP_OR,  8'h00, 8'h00, 1'b0, 8'h00, 4'b1000};
    vecs[6]  = '{OP_CP,  8'h42, 8'h42, 1'b0, 8'h42, 4'b1100};
    vecs[7]  = '{OP_ADC, 8'h0F, 8'h00, 1'b1, 8'h10, 4'b0010};
    vecs[8]  = '{OP_SUB, 8'h00, 8'h01, 1'b0, 8'hFF, 4'b0111};
    vecs[9]  = '{OP_SBC, 8'h10, 8'h00, 1'b1, 8'h0F, 4'b0110};
    vecs[10] = '{OP_CP,  8'h10, 8'h20, 1'b0, 8'h10, 4'b0101};
    vecs[11] = '{OP_ADC, 8'hFF, 8'h00, 1'b1, 8'h00, 4'b1011};
    vecs[12] = '{OP_ADD, 8'h01, 8'h01, 1'b1, 8'h02, 4'b0000};
    vecs[13] = '{OP_OR,  8'h0C, 8'h30, 1'b1, 8'h3C, 4'b0000};

    // Reset state
    #12;
    check("reset_outputs", all_outputs(), 64'd0);
    check("reset_state", {61'b0, dbg_state}, 64'd0);
    @(negedge clk);
    reset = 1'b0;

    // Table-driven ops
    for (int i = 0; i < NV; i++) begin
      exp_q.push_back({vecs[i].res, vecs[i].flags});
      send_req(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].c);
      wait_rsp(lat);
      check($sformatf("v%0d_latency", i), 64'(lat), 64'd6);
      compare_rsp($sformatf("v%0d", i));
      release_rsp($sformatf("v%0d", i));
    end

    // Response back-pressure: everything holds, extra requests ignored
    exp_q.push_back({8'h90, 4'b0010});
    send_req(OP_ADD, 8'h8F, 8'h01, 1'b0);
    wait_rsp(lat);
    compare_rsp("hold_first");
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      req_valid = 1'b1;
      req_op    = OP_OR;
      req_a     = 8'h0F;
      req_b     = 8'hF0;
      req_carry = 1'b0;
      @(posedge clk);
      #1;
      check($sformatf("hold%0d_valid", k), {63'b0, rsp_valid}, 64'd1);
      check($sformatf("hold%0d_result", k), {56'b0, rsp_result}, 64'h90);
      check($sformatf("hold%0d_flags", k), {60'b0, rsp_flags}, 64'b0010);
      check($sformatf("hold%0d_req_ready", k), {63'b0, req_ready}, 64'd0);
    end
    // Release the response while a request is still offered
    @(negedge clk);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    req_valid = 1'b0;
    check("hold_rsp_drop", {63'b0, rsp_valid}, 64'd0);
`ifdef SM83_ALU_SEQ_PIPE_EN
    check("pipe_state_lda", {61'b0, dbg_state}, 64'd1);
    exp_q.push_back({8'hFF, 4'b0000});
    wait_rsp(lat);
    check("pipe_latency", 64'(lat), 64'd6);
    compare_rsp("pipe");
    release_rsp("pipe");
`else
    check("nopipe_state_idle", {61'b0, dbg_state}, 64'd0);
    check("nopipe_req_ready", {63'b0, req_ready}, 64'd1);
    @(posedge clk);
    #1;
    check("nopipe_not_accepted", {61'b0, dbg_state}, 64'd0);
`endif

    // Reset in the middle of an operation
    send_req(OP_ADD, 8'h12, 8'h34, 1'b0);
    n = 0;
    while (dbg_state != 3'd4 && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("reach_high", {61'b0, dbg_state}, 64'd4);
    #2;
    reset = 1'b1;
    #1;
    check("midreset_outputs", all_outputs(), 64'd0);
    check("midreset_state", {61'b0, dbg_state}, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    seen = 0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk);
      #1;
      if (rsp_valid) seen++;
    end
    check("midreset_no_rsp", 64'(seen), 64'd0);
    exp_q.push_back({8'h02, 4'b0000});
    send_req(OP_ADD, 8'h01, 8'h01, 1'b0);
    wait_rsp(lat);
    check("post_reset_latency", 64'(lat), 64'd6);
    compare_rsp("post_reset");
    release_rsp("post_reset");

    check("exp_q_empty", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
